// File: rtl/cntr_mod_n.sv
// Modulo-N up/down counter with enable, parallel load, wrap/saturate mode.
// Combinational tc allows ripple cascading: lower tc feeds upper ce.
module cntr_mod_n #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = 0,
  parameter int RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
  localparam logic             DO_WRAP = (SATURATE == 0);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_zero;
  logic             up_step, dn_step;
  logic             din_big;

  // Compare one bit wider so MODULUS == 2**WIDTH cannot alias.
  assign at_max  = ({1'b0, cnt_q} == MAX_X);
  assign at_zero = (cnt_q == '0);
  assign din_big = ({1'b0, din} > MAX_X);

  assign up_step = ce & dir;
  assign dn_step = ce & ~dir;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    priority case (1'b1)
      load: begin
        cnt_d = din_big ? MAX_W : din;
      end
      up_step & ~at_max: begin
        cnt_d = cnt_q + 1'b1;
      end
      up_step & at_max: begin
        cnt_d  = DO_WRAP ? '0 : cnt_q;
        wrap_d = DO_WRAP;
      end
      dn_step & ~at_zero: begin
        cnt_d = cnt_q - 1'b1;
      end
      dn_step & at_zero: begin
        cnt_d  = DO_WRAP ? MAX_W : cnt_q;
        wrap_d = DO_WRAP;
      end
      default: begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= RST_W;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = cnt_q;
  assign wrap = wrap_q;
  assign tc   = ce & ((dir & at_max) | (~dir & at_zero));

endmodule

// File: tb/tb_cntr_mod_n.sv
// Randomized and directed bench for cntr_mod_n against an integer model.
// Four configurations share stimulus; a separate pair checks cascading.
module tb_cntr_mod_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ce, load, dir;
  logic [3:0] din;
  logic [3:0] out_a, out_b;
  logic [2:0] out_c;
  logic [0:0] out_d;
  logic       tc_a, tc_b, tc_c, tc_d;
  logic       wrap_a, wrap_b, wrap_c, wrap_d;

  logic       cas_ce;
  logic [3:0] out_l, out_u;
  logic       tc_l, tc_u, wrap_l, wrap_u;

  int n_run = 0;
  int n_fail = 0;

  int MODS[4] = '{10, 10, 8, 2};
  int WIDS[4] = '{4, 4, 3, 1};
  bit SATS[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int mo[4];
  int mw[4];

  cntr_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RST_VAL(0)) u_a (
    .clk(clk), .rst(rst), .ce(ce), .load(load), .din(din), .dir(dir),
    .out(out_a), .tc(tc_a), .wrap(wrap_a));

  cntr_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RST_VAL(0)) u_b (
    .clk(clk), .rst(rst), .ce(ce), .load(load), .din(din), .dir(dir),
    .out(out_b), .tc(tc_b), .wrap(wrap_b));

  cntr_mod_n #(.WIDTH(3), .MODULUS(8), .SATURATE(0), .RST_VAL(0)) u_c (
    .clk(clk), .rst(rst), .ce(ce), .load(load), .din(din[2:0]), .dir(dir),
    .out(out_c), .tc(tc_c), .wrap(wrap_c));

  cntr_mod_n #(.WIDTH(1), .MODULUS(2), .SATURATE(0), .RST_VAL(0)) u_d (
    .clk(clk), .rst(rst), .ce(ce), .load(load), .din(din[0:0]), .dir(dir),
    .out(out_d), .tc(tc_d), .wrap(wrap_d));

  cntr_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RST_VAL(0)) u_lo (
    .clk(clk), .rst(rst), .ce(cas_ce), .load(1'b0), .din(4'd0), .dir(1'b1),
    .out(out_l), .tc(tc_l), .wrap(wrap_l));

  cntr_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RST_VAL(0)) u_hi (
    .clk(clk), .rst(rst), .ce(tc_l), .load(1'b0), .din(4'd0), .dir(1'b1),
    .out(out_u), .tc(tc_u), .wrap(wrap_u));

  function automatic int get_o(input int i);
    case (i)
      0: return int'(out_a);
      1: return int'(out_b);
      2: return int'(out_c);
      default: return int'(out_d);
    endcase
  endfunction

  function automatic logic get_tc(input int i);
    case (i)
      0: return tc_a;
      1: return tc_b;
      2: return tc_c;
      default: return tc_d;
    endcase
  endfunction

  function automatic logic get_w(input int i);
    case (i)
      0: return wrap_a;
      1: return wrap_b;
      2: return wrap_c;
      default: return wrap_d;
    endcase
  endfunction

  // Behavioural next-state from the counting rules, integer arithmetic.
  function automatic void model_step(input int i);
    int m, d, n;
    m = MODS[i];
    d = int'(din) % (1 << WIDS[i]);
    mw[i] = 0;
    if (rst) mo[i] = 0;
    else if (load) mo[i] = (d < m) ? d : m - 1;
    else if (ce) begin
      n = mo[i] + (dir ? 1 : -1);
      if (n < 0 || n >= m) begin
        if (!SATS[i]) begin
          mo[i] = (n + m) % m;
          mw[i] = 1;
        end
      end else mo[i] = n;
    end
  endfunction

  task automatic tick(input string tag);
    logic etc;
    #1;
    for (int i = 0; i < 4; i++) begin
      etc = ce && ((dir && mo[i] == MODS[i] - 1) || (!dir && mo[i] == 0));
      n_run++;
      if (get_tc(i) !== etc) begin
        n_fail++;
        $display("FAIL %s tc[%0d]: got %0b want %0b", tag, i, get_tc(i), etc);
      end
    end
    for (int i = 0; i < 4; i++) model_step(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_run++;
      if (get_o(i) !== mo[i]) begin
        n_fail++;
        $display("FAIL %s out[%0d]: got %0d want %0d", tag, i, get_o(i), mo[i]);
      end
      n_run++;
      if (get_w(i) !== mw[i][0]) begin
        n_fail++;
        $display("FAIL %s wrap[%0d]: got %0b want %0b", tag, i, get_w(i), mw[i][0]);
      end
    end
  endtask

  task automatic drive(input logic r, input logic ld, input int d,
                       input logic c, input logic dr);
    rst = r; load = ld; din = 4'(d); ce = c; dir = dr;
  endtask

  task automatic test_reset();
    drive(1, 1, 7, 1, 1);
    tick("reset");
    n_run++;
    if (out_a !== 4'd0 || wrap_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: got out=%0d wrap=%0b want 0 0", out_a, wrap_a);
    end
  endtask

  task automatic test_count_up();
    drive(1, 0, 0, 0, 1);
    tick("up_rst");
    drive(0, 0, 0, 1, 1);
    for (int k = 1; k <= 12; k++) begin
      tick("up");
      n_run++;
      if (out_a !== 4'(k % 10) || wrap_a !== (k == 10)) begin
        n_fail++;
        $display("FAIL up_seq k=%0d: got out=%0d wrap=%0b want %0d %0b",
                 k, out_a, wrap_a, k % 10, k == 10);
      end
    end
  endtask

  task automatic test_count_down();
    int exp_o[4] = '{1, 0, 9, 8};
    drive(0, 1, 2, 0, 0);
    tick("dn_load");
    drive(0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      tick("down");
      n_run++;
      if (out_a !== 4'(exp_o[k]) || wrap_a !== (k == 2)) begin
        n_fail++;
        $display("FAIL down_seq k=%0d: got out=%0d wrap=%0b want %0d %0b",
                 k, out_a, wrap_a, exp_o[k], k == 2);
      end
    end
  endtask

  task automatic test_saturate();
    drive(1, 0, 0, 0, 1);
    tick("sat_rst");
    drive(0, 0, 0, 1, 1);
    for (int k = 0; k < 14; k++) tick("sat_up");
    n_run++;
    if (out_b !== 4'd9 || wrap_b !== 1'b0 || tc_b !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_hold: got out=%0d wrap=%0b tc=%0b want 9 0 1",
               out_b, wrap_b, tc_b);
    end
    dir = 0;
    tick("sat_dn");
    tick("sat_dn");
    n_run++;
    if (out_b !== 4'd7) begin
      n_fail++;
      $display("FAIL sat_down: got %0d want 7", out_b);
    end
  endtask

  task automatic test_load();
    drive(0, 1, 6, 0, 1);
    tick("load6");
    n_run++;
    if (out_a !== 4'd6) begin
      n_fail++;
      $display("FAIL load6: got %0d want 6", out_a);
    end
    din = 4'd13;
    tick("load13");
    n_run++;
    if (out_a !== 4'd9) begin
      n_fail++;
      $display("FAIL load_clamp: got %0d want 9", out_a);
    end
    drive(0, 1, 3, 1, 1);
    tick("load_tc");
    n_run++;
    if (out_a !== 4'd3 || wrap_a !== 1'b0) begin
      n_fail++;
      $display("FAIL load_over_tc: got out=%0d wrap=%0b want 3 0", out_a, wrap_a);
    end
  endtask

  task automatic test_ce_toggle();
    int exp_o[4] = '{9, 9, 0, 0};
    drive(0, 1, 8, 0, 1);
    tick("ce_load");
    load = 0;
    for (int k = 0; k < 4; k++) begin
      ce = (k % 2 == 0);
      #1;
      n_run++;
      if (!ce && tc_a !== 1'b0) begin
        n_fail++;
        $display("FAIL ce_tc k=%0d: got %0b want 0", k, tc_a);
      end
      tick("ce_tog");
      n_run++;
      if (out_a !== 4'(exp_o[k])) begin
        n_fail++;
        $display("FAIL ce_seq k=%0d: got %0d want %0d", k, out_a, exp_o[k]);
      end
    end
  endtask

  task automatic test_rst_load();
    drive(0, 1, 7, 0, 1);
    tick("rl_load");
    drive(1, 1, 5, 1, 1);
    tick("rst_load");
    n_run++;
    if (out_a !== 4'd0 || wrap_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_over_load: got out=%0d wrap=%0b want 0 0", out_a, wrap_a);
    end
    rst = 0;
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, 0, 0);
    tick("b2b_rst");
    drive(0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      dir = k[0];
      tick("b2b");
      n_run++;
      if (wrap_d !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_wrap k=%0d: got %0b want 1", k, wrap_d);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)));
      tick("rand");
    end
  endtask

  task automatic test_cascade();
    int cnt = 0;
    drive(1, 0, 0, 0, 1);
    cas_ce = 1'b0;
    tick("cas_rst");
    rst = 0;
    cas_ce = 1'b1;
    for (int k = 0; k < 150; k++) begin
      @(posedge clk);
      #1;
      cnt++;
      n_run++;
      if (out_l !== 4'(cnt % 10) || out_u !== 4'((cnt / 10) % 10)) begin
        n_fail++;
        $display("FAIL cascade n=%0d: got %0d%0d want %0d", cnt, out_u, out_l,
                 cnt % 100);
      end
      n_run++;
      if (wrap_u !== (cnt % 100 == 0)) begin
        n_fail++;
        $display("FAIL cascade_wrap n=%0d: got %0b want %0b", cnt, wrap_u,
                 cnt % 100 == 0);
      end
    end
    cas_ce = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cas_ce = 1'b0;
    drive(1, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      mo[i] = 0;
      mw[i] = 0;
    end
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load();
    test_ce_toggle();
    test_rst_load();
    test_back_to_back();
    test_random();
    test_cascade();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/cntr_mod_n.md
Name: cntr_mod_n

Overview:
Parametrised modulo-N up/down counter with clock enable, synchronous parallel load, and wrap or saturate mode. It is the general successor of the fixed 2-bit enable counter. It serves as the common counting primitive for clock dividers, BCD digit chains and timeout generators. A combinational terminal-count output lets instances cascade, with the lower stage's tc driving the upper stage's ce.

Parameters:
WIDTH, 4, bit width of count value; 1..16.
MODULUS, 10, number of states; count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.
RST_VAL, 0, value loaded on reset; must be < MODULUS.

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  synchronous reset, active-high
ce  in  1  count enable; one step per clk while high
load  in  1  synchronous parallel load, independent of ce
din  in  WIDTH  load value
dir  in  1  1 = count up, 0 = count down
out  out  WIDTH  registered count value
tc  out  1  combinational terminal count: ce high AND count at end of range for current dir
wrap  out  1  registered one-cycle pulse, asserted the cycle after a wrap transition

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). No asynchronous paths.
- Priority per rising edge: rst > load > ce > hold.
- rst: out <= RST_VAL, wrap <= 0. tc then follows its combinational equation: 0 unless ce and RST_VAL is at a range end.
- load=1: out <= din if din < MODULUS, else out <= MODULUS-1 (clamp). Load applies whether ce is high or low, overrides counting in that cycle, and forces wrap <= 0.
- ce=1, load=0, dir=1:
  - out < MODULUS-1: out <= out+1.
  - out = MODULUS-1, SATURATE=0: out <= 0, wrap <= 1.
  - out = MODULUS-1, SATURATE=1: out holds, wrap <= 0.
- ce=1, load=0, dir=0:
  - out > 0: out <= out-1.
  - out = 0, SATURATE=0: out <= MODULUS-1, wrap <= 1.
  - out = 0, SATURATE=1: out holds, wrap <= 0.
- ce=0, load=0: out holds, wrap <= 0.
- wrap is exactly one cycle wide per wrap event. Back-to-back wraps (e.g. MODULUS=2 alternating dir) give consecutive high cycles. wrap is constant 0 when SATURATE=1.
- tc = ce & ((dir & out==MODULUS-1) | (~dir & out==0)). It is purely combinational from registered out and live ce/dir, with zero latency, for cascading. tc asserts in saturate mode too. tc ignores load and rst.
- dir may change on any cycle. The next step uses the dir value sampled at that edge. No extra latency on a direction change.
- Arithmetic: next-state compare is done at WIDTH+1 bits, so MODULUS = 2**WIDTH wraps correctly with no overflow aliasing.
- Reset mid-count: the next edge gives out=RST_VAL regardless of ce/load/dir. No pending wrap survives reset.
- Simultaneous rst and load: rst wins. Simultaneous load and terminal count: load wins, no wrap pulse.
- out must never take a value >= MODULUS after reset, in any mode.

Test Plan:
1. WIDTH=4, MODULUS=10, SATURATE=0, dir=1, ce=1 from reset for 12 cycles -> out 0,1..9,0,1; wrap high only on the cycle out first shows 0 after 9; tc high while out=9.
2. Same config, dir=0 from out=2 for 4 cycles -> out 1,0,9,8; wrap pulses once, after the 0->9 transition; tc high while out=0.
3. SATURATE=1, dir=1, ce=1 for 14 cycles -> out sticks at 9; wrap stays 0; tc stays 1. Then dir=0 -> out 8,7.
4. load=1 with din=6, then din=13, with ce=0 -> out=6, then out=9 (clamped). load together with ce=1 at out=9 -> out=din, wrap=0.
5. ce toggled 1,0,1,0 with dir=1 -> out advances only on ce=1 cycles; tc=0 whenever ce=0, even with out=9.
6. rst asserted together with load=1, din=5, while out=7 -> out=RST_VAL (0), wrap=0. Then cascade two instances (lower tc -> upper ce) counting 0..99 -> upper increments exactly when lower goes 9->0.
